// File: rtl/chunked_adder_seq_pkg.sv
// rtl/chunked_adder_seq_pkg.sv - shared types and defaults for the chunked adder sequencer
package chunked_adder_seq_pkg;

  localparam int CHUNK_W_DEFAULT    = 10;
  localparam int NUM_CHUNKS_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chunked_adder_seq_chunk_adder.sv
// rtl/chunked_adder_seq_chunk_adder.sv - combinational CHUNK_W-bit adder slice
// Ports:
//   a, b : addend chunks
//   ci   : carry in
//   s    : sum chunk
//   co   : carry out
module chunk_adder #(
  parameter int CHUNK_W = 10
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               ci,
  output logic [CHUNK_W-1:0] s,
  output logic               co
);

  // One extra bit captures the carry out of the slice.
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK_W{1'b0}}, ci};

endmodule

// File: rtl/chunked_adder_seq.sv
// rtl/chunked_adder_seq.sv - wide adder that runs one narrow slice over the operands LSB chunk first
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (op_a, op_b, cin)
//   out_valid / out_ready: result handshake (sum, cout)
//   busy                 : high while chunks are being added
module chunked_adder_seq
  import chunked_adder_seq_pkg::*;
#(
  parameter int  CHUNK_W    = CHUNK_W_DEFAULT,
  parameter int  NUM_CHUNKS = NUM_CHUNKS_DEFAULT,
  localparam int W          = CHUNK_W * NUM_CHUNKS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_t             state_q, state_d;
  logic [W-1:0]       a_reg, b_reg, sum_reg;
  logic               carry_reg, cout_reg;
  logic [IDX_W-1:0]   idx;

  logic [CHUNK_W-1:0] a_sel, b_sel, slice_s;
  logic               slice_co;
  logic               last_chunk;
  logic               accept;

  assign last_chunk = (idx == LAST_IDX);
  assign accept     = in_valid & in_ready;

  // Chunk select for the slice inputs.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (idx == IDX_W'(k)) begin
        a_sel = a_reg[k*CHUNK_W +: CHUNK_W];
        b_sel = b_reg[k*CHUNK_W +: CHUNK_W];
      end
    end
  end

  chunk_adder #(
    .CHUNK_W (CHUNK_W)
  ) u_slice (
    .a  (a_sel),
    .b  (b_sel),
    .ci (carry_reg),
    .s  (slice_s),
    .co (slice_co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Taking the result frees the operand slot in the same cycle,
        // so a waiting operand set starts with no bubble.
        in_ready  = out_ready;
        if (out_ready) state_d = in_valid ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand, carry, index and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else if (accept) begin
      a_reg     <= op_a;
      b_reg     <= op_b;
      carry_reg <= cin;
      idx       <= '0;
    end else if (state_q == RUN) begin
      for (int k = 0; k < NUM_CHUNKS; k++) begin
        if (idx == IDX_W'(k)) sum_reg[k*CHUNK_W +: CHUNK_W] <= slice_s;
      end
      carry_reg <= slice_co;
      if (last_chunk) begin
        cout_reg <= slice_co;
        idx      <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule
